// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared fetch-sequencer types and constants
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_TRAP_VECTOR_DEFAULT  = 32'h0000_0100;
    localparam logic [31:0] PC_INCR                 = 32'd4;

endpackage

// File: rtl/pc_sequencer_fetch_out_reg.sv
// rtl/pc_sequencer_fetch_out_reg.sv - fetched-instruction holding register toward decode
module fetch_out_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        clear_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    // Capture a fresh instruction, hold it until consumed or dropped by a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - single-outstanding instruction fetch sequencer (optional PC_SEQ_MISALIGN_TRAP_EN)
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR_DEFAULT,
    parameter logic [31:0] TRAP_VECTOR  = PC_TRAP_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        trap_valid
);

    pc_state_t   state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        stale_q;
    logic        redir_trap;
    logic [31:0] redir_pc;

    // Redirects are only honoured once the sequencer has left IDLE.
    logic take_redirect;
    logic out_fire;
    logic load_out;
    logic clear_out;

    assign take_redirect = redirect_valid && (state_q != ST_IDLE);
    assign out_fire      = (state_q == ST_OUT) && if_ready;
    assign load_out      = (state_q == ST_WAIT) && imem_resp_valid && !stale_q && !take_redirect;
    assign clear_out     = (state_q == ST_OUT) && (if_ready || take_redirect);

    // Redirect destination and next pc; a redirect outranks the sequential increment.
    always_comb begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
        redir_trap = (redirect_target[1:0] != 2'b00);
        redir_pc   = redir_trap ? TRAP_VECTOR : redirect_target;
`else
        redir_trap = 1'b0;
        redir_pc   = {redirect_target[31:2], 2'b00};
`endif
        pc_d = pc_q;
        if (take_redirect) begin
            pc_d = redir_pc;
        end else if (out_fire) begin
            pc_d = pc_q + PC_INCR;
        end
    end

`ifndef PC_SEQ_MISALIGN_TRAP_EN
    logic unused_cfg_bits;
    assign unused_cfg_bits = ^{redirect_target[1:0], TRAP_VECTOR, redir_trap};
`endif

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    logic trap_q;
`endif

    // Fetch FSM: state, pc, stale-response flag and trap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            stale_q <= 1'b0;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            trap_q <= take_redirect && redir_trap;
`endif
            case (state_q)
                ST_IDLE: state_q <= ST_REQ;
                ST_REQ: begin
                    // Accepted together with a redirect: the response belongs to the old path.
                    if (imem_req_ready) begin
                        state_q <= ST_WAIT;
                        stale_q <= take_redirect;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        stale_q <= 1'b0;
                        state_q <= (stale_q || take_redirect) ? ST_REQ : ST_OUT;
                    end else if (take_redirect) begin
                        stale_q <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (if_ready || take_redirect) begin
                        state_q <= ST_REQ;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state_q == ST_REQ);
    assign imem_req_addr  = pc_q;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign trap_valid = trap_q;
`else
    assign trap_valid = 1'b0;
`endif

    fetch_out_reg u_fetch_out_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_out),
        .pc_i    (pc_q),
        .instr_i (imem_resp_data),
        .clear_i (clear_out),
        .valid_o (if_valid),
        .pc_o    (if_pc),
        .instr_o (if_instr)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
module tb_pc_sequencer;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [31:0] RST_VEC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        trap_valid;

    int checks = 0;
    int errors = 0;

    pc_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_instr        (if_instr),
        .trap_valid      (trap_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic        ifr;
        logic        rv;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_pc;
        logic        e_trap;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] redir_dest(input logic [31:0] t);
        if (TRAP_EN && (t[1:0] != 2'b00)) return TRAP_VEC;
        return {t[31:2], 2'b00};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic add_row(input logic rdy, input logic rsp, input logic ifr, input logic rv,
                           input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                           input logic e_ifv, input logic [31:0] e_pc, input logic e_trap);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.ifr = ifr; v.rv = rv; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_ifv = e_ifv; v.e_pc = e_pc; v.e_trap = e_trap;
        tbl.push_back(v);
    endtask

    task automatic clear_inputs();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        if_ready        = 1'b0;
    endtask

    // Leaves the bench at a falling edge with rst just released (DUT in IDLE).
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_trap_valid", 32'(trap_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        rst = 1'b0;
    endtask

    // Issue one fetch at exp_addr, answer it after one cycle and hand it to decode.
    task automatic fetch_one(input string tag, input logic [31:0] exp_addr);
        int n = 0;
        clear_inputs();
        imem_req_ready = 1'b1;
        while (!imem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_req_addr"}, imem_req_addr, exp_addr);
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_f(exp_addr);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk({tag, "_if_valid"}, 32'(if_valid), 32'd1);
        chk({tag, "_if_pc"}, if_pc, exp_addr);
        chk({tag, "_if_instr"}, if_instr, mem_f(exp_addr));
        if_ready = 1'b1;
        @(negedge clk);
        if_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mis_pc;
        logic        mis_trap;
        logic [31:0] last_acc;
        logic [31:0] exp_pc;
        logic        exp_trap;
        logic        prev_ifv;
        logic        prev_used;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        int          pend_n;
        logic [31:0] pend_addr;
        int          pend_lat;
        int          handshakes;

        mis_pc   = TRAP_EN ? TRAP_VEC : 32'h0000_0200;
        mis_trap = TRAP_EN;
        last_acc = 32'd0;

        //       rdy   rsp   ifr   rv    tgt            req   addr           ifv   pc             trap
        add_row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h0,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h4,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h4,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h8,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        for (int i = 0; i < 5; i++)
            add_row(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,       1'b1, 32'h8,       1'b0);
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, 32'h8,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'hC,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 32'h200,     1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, 32'h200,     1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b0, 1'b1, 1'b1, 32'h300,     1'b0, 32'h0,       1'b1, 32'h200,     1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 32'h202,     1'b1, 32'h300,     1'b0, 32'h0,       1'b0);
        add_row(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,       1'b1, mis_pc,      1'b0, 32'h0,       mis_trap);
        add_row(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,       1'b0, 32'h0,       1'b0, 32'h0,       1'b0);
        add_row(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 32'h0,       1'b1, mis_pc,      1'b0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            if (i > 0) @(negedge clk);
            imem_req_ready  = tbl[i].rdy;
            imem_resp_valid = tbl[i].rsp;
            imem_resp_data  = mem_f(last_acc);
            if_ready        = tbl[i].ifr;
            redirect_valid  = tbl[i].rv;
            redirect_target = tbl[i].tgt;
            if (tbl[i].rdy && imem_req_valid) last_acc = imem_req_addr;
            chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].e_ifv));
            chk($sformatf("v%0d_trap", i), 32'(trap_valid), 32'(tbl[i].e_trap));
            if (tbl[i].e_req) chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            if (tbl[i].e_ifv) begin
                chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].e_pc);
                chk($sformatf("v%0d_if_instr", i), if_instr, mem_f(tbl[i].e_pc));
            end
        end

        // Wrap of the pc past the top of the address space.
        @(negedge clk);
        clear_inputs();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        @(negedge clk);
        clear_inputs();
        fetch_one("wrap_top", 32'hFFFF_FFFC);
        fetch_one("wrap_zero", 32'h0000_0000);

        // Reset while a response is outstanding; late responses are ignored.
        clear_inputs();
        imem_req_ready = 1'b1;
        @(negedge clk);
        clear_inputs();
        rst             = 1'b1;
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_f(32'h4);
        @(negedge clk);
        chk("rstwait_if_valid", 32'(if_valid), 32'd0);
        chk("rstwait_req_valid", 32'(imem_req_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        chk("rstwait_if_valid_after", 32'(if_valid), 32'd0);
        fetch_one("rstwait_fetch", RST_VEC);

        // Randomized traffic against a transaction-level model.
        do_reset();
        exp_pc     = RST_VEC;
        exp_trap   = 1'b0;
        prev_ifv   = 1'b0;
        prev_used  = 1'b0;
        prev_pc    = 32'd0;
        prev_instr = 32'd0;
        pend_n     = 0;
        pend_addr  = 32'd0;
        pend_lat   = 0;
        handshakes = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (trap_valid !== exp_trap) chk("rnd_trap", 32'(trap_valid), 32'(exp_trap));
            if (prev_ifv && !prev_used) begin
                if (!if_valid || if_pc !== prev_pc || if_instr !== prev_instr) begin
                    chk("rnd_hold_valid", 32'(if_valid), 32'd1);
                    chk("rnd_hold_pc", if_pc, prev_pc);
                    chk("rnd_hold_instr", if_instr, prev_instr);
                end
            end

            imem_req_ready  = 1'($urandom_range(0, 1));
            if_ready        = ($urandom_range(0, 9) < 6);
            redirect_valid  = (cyc > 2) && ($urandom_range(0, 11) == 0);
            redirect_target = $urandom;
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
            if (pend_n > 0) begin
                if (pend_lat == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_f(pend_addr);
                    pend_n = 0;
                end else begin
                    pend_lat--;
                end
            end

            if (imem_req_valid && imem_req_ready) begin
                chk("rnd_req_addr", imem_req_addr, exp_pc);
                if (pend_n != 0) chk("rnd_outstanding", 32'(pend_n + 1), 32'd1);
                pend_n    = pend_n + 1;
                pend_addr = imem_req_addr;
                pend_lat  = $urandom_range(0, 3);
            end
            if (if_valid && if_ready) begin
                chk("rnd_if_pc", if_pc, exp_pc);
                chk("rnd_if_instr", if_instr, mem_f(if_pc));
                exp_pc = exp_pc + 32'd4;
                handshakes++;
            end
            if (redirect_valid) exp_pc = redir_dest(redirect_target);
            exp_trap   = redirect_valid && TRAP_EN && (redirect_target[1:0] != 2'b00);
            prev_ifv   = if_valid;
            prev_used  = if_valid && (if_ready || redirect_valid);
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end
        chk("rnd_progress", 32'(handshakes > 150), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, the fetch address after a misaligned-redirect trap.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports imem_req_valid out 1, imem_req_ready in 1, imem_req_addr out 32: the instruction-memory request handshake.
REQ-006 SHALL have ports imem_resp_valid in 1, imem_resp_data in 32: the instruction-memory response, always accepted.
REQ-007 SHALL have ports redirect_valid in 1, redirect_target in 32: the branch/JALR redirect from execute, a single-cycle pulse.
REQ-008 SHALL have ports if_valid out 1, if_ready in 1, if_pc out 32, if_instr out 32: the fetched-instruction handshake to decode.
REQ-009 SHALL have port trap_valid out 1, a one-cycle misaligned-target trap pulse.

Function
REQ-010 SHALL hold a 32-bit pc register and a 4-state FSM: IDLE, REQ, WAIT, OUT.
REQ-011 SHALL define IDLE as follows: one cycle after reset, then go to REQ; all valid outputs are 0.
REQ-012 SHALL, in REQ, drive imem_req_valid=1 and imem_req_addr=pc, and go to WAIT on the cycle in which imem_req_ready=1.
REQ-013 SHALL, in WAIT, capture imem_resp_data into an instruction register on imem_resp_valid and go to OUT; a response arrives no earlier than the cycle after acceptance.
REQ-014 SHALL, in OUT, drive if_valid=1, if_pc=pc and if_instr=the captured data, holding them stable until if_ready=1; on that handshake set pc <= pc+4 and go to REQ.
REQ-015 SHALL compute pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-016 SHALL keep at most one request outstanding.
REQ-017 SHALL, on a redirect_valid in any non-IDLE state, load pc <= target on the next cycle, and a redirect SHALL take priority over pc+4.
REQ-018 SHALL, on a redirect in REQ with no acceptance that cycle, go to REQ; imem_req_addr may change (the request is abandoned).
REQ-019 SHALL, on a redirect in REQ with acceptance the same cycle, or a redirect in WAIT, set a stale flag, go to WAIT, discard the next response, clear the flag, and go to REQ.
REQ-020 SHALL, on a redirect in WAIT in the same cycle as imem_resp_valid, discard that response and go to REQ.
REQ-021 SHALL, on a redirect in OUT, drop the held instruction: if_valid=0 next cycle, then go to REQ. If if_ready=1 in the same cycle, the handshake completes and the redirect still sets pc.
REQ-022 SHALL give best-case throughput of one instruction per 3 cycles (REQ, WAIT, OUT).

Reset
REQ-023 SHALL, while rst=1, force: pc=RESET_VECTOR, state=IDLE, stale=0, and imem_req_valid=if_valid=trap_valid=0; if_instr=0.
REQ-024 SHALL, on reset during WAIT, discard any response arriving in or after the reset cycle, and SHALL ignore all inputs while rst=1.

Configuration
REQ-025 SHALL, with macro PC_SEQ_MISALIGN_TRAP_EN defined, treat a redirect_target with [1:0]!=0 as a trap: pulse trap_valid=1 for one cycle, set pc <= TRAP_VECTOR, and otherwise apply REQ-017..021 unchanged.
REQ-026 SHALL, without PC_SEQ_MISALIGN_TRAP_EN, tie trap_valid to 0 and load pc <= {redirect_target[31:2],2'b00}.

Structure
REQ-027 SHALL place the FSM state enum, the default vectors, and the constant 32'd4 in the shared processor package.
REQ-028 SHALL isolate the fetch-output register (if_valid/if_pc/if_instr hold-and-drop) as sub-module fetch_out_reg.

Verification
REQ-029 SHALL cover: reset release with imem_req_ready=1 and a 1-cycle response -> addresses 0x0, 0x4, 0x8 issued every 3 cycles.
REQ-030 SHALL cover: if_ready=0 for 5 cycles in OUT -> if_pc/if_instr stable and no new imem_req_valid.
REQ-031 SHALL cover: redirect to 0x200 in WAIT -> the pending response is dropped, with no if_valid for it, and the next request addr is 0x200.
REQ-032 SHALL cover: redirect to 0x300 in OUT together with if_ready=1 -> one handshake, then a request to 0x300.
REQ-033 SHALL cover: pc=0xFFFF_FFFC handshake -> next request addr 0x0.
REQ-034 SHALL cover: redirect to 0x202 -> with the macro, trap_valid pulse and next addr 0x100; without it, no trap and next addr 0x200.
